mem_port_arbiter: RTL and testbench

Shares the single unified memory port between instruction fetch (IF) and data access (MEM stage lw/sw, driven by MemR/MemW). Sequences each transaction through a small FSM with a variable-latency memory handshake. Returns read data and a one-cycle acknowledge to the winning requester. Exports a pipeline stall so IF/ID/EX/MEM registers hold while any request is unserved.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_arb_prio_sel.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states and grant IDs.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_arb_prio_sel.sv
// Winner selection between instruction fetch and data access.
// Data wins by default (older instruction). With ARB_STARVE_GUARD_EN defined,
// a counter of data grants made while fetch waits forces a fetch grant once it
// reaches STARVE_MAX.
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req,
  input  logic dm_req,
  output logic sel_dm
);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          force_if;

  // Fetch is forced once data has won STARVE_MAX times in a row over a waiting fetch.
  always_comb begin
    force_if = if_req && (cnt_q == CW'(STARVE_MAX));
    sel_dm   = dm_req && !force_if;
  end

  // Counter only moves on IDLE cycles, where grants are decided.
  always_comb begin
    cnt_d = cnt_q;
    if (idle) begin
      if (!if_req)     cnt_d = '0;
      else if (sel_dm) cnt_d = cnt_q + CW'(1);
      else             cnt_d = '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_ok;

  // Strict data-over-fetch priority.
  always_comb begin
    sel_dm    = dm_req;
    unused_ok = ^{clk, rst, idle, if_req, 32'(STARVE_MAX)};
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// Each transaction runs IDLE -> BUSY (until mem_ready) -> RESP (one-cycle ack).
// Optional build macro: ARB_STARVE_GUARD_EN (fetch starvation guard in arb_prio_sel).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              pipe_stall
);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              sel_dm;

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .clk    (clk),
    .rst    (rst),
    .idle   (state_q == ST_IDLE),
    .if_req (if_req),
    .dm_req (dm_req),
    .sel_dm (sel_dm)
  );

  // Next-state and registered-output computation for the transaction FSM.
  // Acks are raised on the BUSY->RESP edge so they are high exactly during RESP.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          mem_req_d   = 1'b1;
          mem_wdata_d = dm_wdata;
          state_d     = ST_BUSY;
          if (sel_dm) begin
            gnt_d      = GNT_DM;
            mem_we_d   = dm_we;
            mem_addr_d = dm_addr;
          end else begin
            gnt_d      = GNT_IF;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          if (gnt_q == GNT_DM) begin
            dm_rdata_d = mem_rdata;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  // Output wiring; the stall is combinational so it drops in the ack cycle.
  always_comb begin
    mem_req    = mem_req_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    if_rdata   = if_rdata_q;
    dm_rdata   = dm_rdata_q;
    if_ack     = if_ack_q;
    dm_ack     = dm_ack_q;
    pipe_stall = (if_req && !if_ack_q) || (dm_req && !dm_ack_q);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_MAX overridden to 2).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        pipe_stall;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_ack     (dm_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pipe_stall (pipe_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr [6];
`ifdef ARB_STARVE_GUARD_EN
    exp_addr = '{32'h200, 32'h200, 32'h100, 32'h200, 32'h200, 32'h100};
`else
    exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h200, 32'h200};
`endif
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_acks", {30'b0, if_ack, dm_ack}, 32'h0);
    check("rst_rdata", if_rdata | dm_rdata, 32'h0);
    rst = 1'b0;
    step();

    // Single fetch, one-cycle memory.
    if_req = 1'b1; if_addr = 32'h0000_3000; #1;
    check("f_stall_req", {31'b0, pipe_stall}, 32'h1);
    step();
    check("f_mem_req", {31'b0, mem_req}, 32'h1);
    check("f_mem_addr", mem_addr, 32'h0000_3000);
    check("f_mem_we", {31'b0, mem_we}, 32'h0);
    check("f_stall_busy", {31'b0, pipe_stall}, 32'h1);
    mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
    step();
    check("f_ack", {31'b0, if_ack}, 32'h1);
    check("f_rdata", if_rdata, 32'h2008_0005);
    check("f_stall_ack", {31'b0, pipe_stall}, 32'h0);
    check("f_mem_req_drop", {31'b0, mem_req}, 32'h0);
    check("f_no_dm_ack", {31'b0, dm_ack}, 32'h0);
    if_req = 1'b0; mem_ready = 1'b0;
    step();
    check("f_ack_pulse", {31'b0, if_ack}, 32'h0);

    // Store with three wait cycles.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    step();
    check("s_mem_req", {31'b0, mem_req}, 32'h1);
    check("s_mem_addr", mem_addr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      check("s_wait_we", {31'b0, mem_we}, 32'h1);
      check("s_wait_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("s_wait_req", {31'b0, mem_req}, 32'h1);
      check("s_wait_noack", {31'b0, dm_ack}, 32'h0);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step();
    check("s_ack", {31'b0, dm_ack}, 32'h1);
    check("s_if_rdata_held", if_rdata, 32'h2008_0005);
    dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    step();
    check("s_ack_pulse", {31'b0, dm_ack}, 32'h0);

    // Simultaneous requests; mem_ready left high to show it is ignored outside BUSY.
    if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_addr = 32'h20;
    mem_ready = 1'b1; mem_rdata = 32'h55;
    step();
    check("c_dm_first", mem_addr, 32'h20);
    check("c_we", {31'b0, mem_we}, 32'h0);
    step();
    check("c_dm_ack", {31'b0, dm_ack}, 32'h1);
    check("c_dm_rdata", dm_rdata, 32'h55);
    check("c_if_waits", {31'b0, if_ack}, 32'h0);
    check("c_stall_if", {31'b0, pipe_stall}, 32'h1);
    dm_req = 1'b0; mem_rdata = 32'h77;
    step();
    check("c_idle", {30'b0, mem_req, if_ack}, 32'h0);
    step();
    check("c_if_addr", mem_addr, 32'h40);
    step();
    check("c_if_ack", {31'b0, if_ack}, 32'h1);
    check("c_if_rdata", if_rdata, 32'h77);
    check("c_dm_rdata_held", dm_rdata, 32'h55);
    if_req = 1'b0;
    step();

    // Starvation: both requesters continuously requesting, zero-wait memory.
    if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_addr = 32'h200;
    for (int t = 0; t < 6; t++) begin
      step();
      check($sformatf("starve_grant%0d", t), mem_addr, exp_addr[t]);
      step();
      check($sformatf("starve_ack%0d", t), {30'b0, if_ack, dm_ack},
            (exp_addr[t] == 32'h100) ? 32'h2 : 32'h1);
      step();
    end
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    step();

    // Reset in the middle of BUSY.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h30; dm_wdata = 32'h1234;
    step();
    check("r_busy", {31'b0, mem_req}, 32'h1);
    rst = 1'b1; #1;
    check("r_async_req", {31'b0, mem_req}, 32'h0);
    check("r_async_we", {31'b0, mem_we}, 32'h0);
    check("r_async_addr", mem_addr, 32'h0);
    check("r_async_wdata", mem_wdata, 32'h0);
    check("r_async_rdata", if_rdata | dm_rdata, 32'h0);
    dm_req = 1'b0; dm_we = 1'b0;
    step();
    rst = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("r_no_ack", {29'b0, mem_req, if_ack, dm_ack}, 32'h0);
    end
    if_req = 1'b1; if_addr = 32'h44; mem_rdata = 32'h99;
    step();
    check("r_fresh_addr", mem_addr, 32'h44);
    step();
    check("r_fresh_ack", {31'b0, if_ack}, 32'h1);
    check("r_fresh_rdata", if_rdata, 32'h99);
    if_req = 1'b0; mem_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
